io_port_bridge: RTL and testbench
=================================

// Module: io_port_bridge
// PURPOSE
//   Host-side end of the datapath's 16-bit I/O interface. It buffers words that the datapath
//   writes on ioOut into an output FIFO that a host drains with valid/ready. It also holds one
//   host-supplied word that drives the datapath's ioIn until the datapath consumes it.
//   Sits between the datapath top and the board/host harness.
// PARAMETERS
//   OUT_DEPTH  4   output FIFO depth in words; power of 2, >= 2
//   IN_RESET   0   16-bit value driven on dp_ioIn out of reset
// PORTS
//   clk            in   1   single clock, all state on rising edge
//   reset          in   1   asynchronous, active-high; clears all state immediately
//   dp_ioOut       in   16  datapath output word
//   dp_out_we      in   1   datapath write strobe: push dp_ioOut this cycle
//   dp_ioIn        out  16  word presented to datapath ioIn
//   dp_in_avail    out  1   1 = dp_ioIn holds an unconsumed host word
//   dp_in_re       in   1   datapath consume strobe for dp_ioIn
//   host_out_data  out  16  head of output FIFO
//   host_out_valid out  1   output FIFO non-empty
//   host_out_ready in   1   host accepts host_out_data
//   host_in_data   in   16  host word toward datapath
//   host_in_valid  in   1   host_in_data valid
//   host_in_ready  out  1   bridge can accept host_in_data
//   err            out  2   [0] output overflow, [1] input underflow (see CONFIGURATION)
//   err_clr        in   1   clears err flags
// BEHAVIOUR
//   Reset values
//     - FIFO empty, count 0; host_out_valid=0; host_out_data=0.
//     - dp_ioIn=IN_RESET; dp_in_avail=0; host_in_ready=1; err=0.
//     - Reset asserted mid-transfer discards all buffered words; no partial state survives.
//   Output path
//     - Circular FIFO with rd/wr pointers of clog2(OUT_DEPTH) bits, wrapping modulo OUT_DEPTH.
//     - count has clog2(OUT_DEPTH)+1 bits; full = (count==OUT_DEPTH); empty = (count==0).
//     - Push = dp_out_we && (!full || pop). Pop = host_out_valid && host_out_ready.
//     - host_out_data is the registered head, first-word-fall-through; host_out_valid = !empty.
//     - Latency: a word pushed on edge N is visible on host_out_valid/data after edge N.
//     - No same-cycle bypass when empty.
//     - Push and pop together when full: both occur, count is unchanged.
//     - Push and pop together when empty: push only.
//     - dp_out_we while full without pop: the word is dropped and FIFO contents are unchanged.
//   Input path
//     - Single holding register; states EMPTY (dp_in_avail=0) and HELD (dp_in_avail=1).
//     - host_in_ready = !dp_in_avail. This is registered state; there is no combinational path
//       from dp_in_re.
//     - EMPTY -> HELD on host_in_valid && host_in_ready; dp_ioIn <= host_in_data.
//     - HELD -> EMPTY on dp_in_re. Host writes in that same cycle are not accepted, because
//       ready is 0.
//     - dp_ioIn keeps the last value after consumption; it changes only on host acceptance
//       or reset.
//     - dp_in_re in EMPTY is an underflow: no state change, dp_ioIn unchanged.
// CONFIGURATION
//   IO_ERR_STICKY_EN defined
//     - err[0] sets on a dropped output push; err[1] sets on an underflow.
//     - Both flags are sticky until err_clr.
//     - If err_clr and a new error occur in the same cycle, the flag sets (set wins).
//   IO_ERR_STICKY_EN undefined
//     - err is constant 0; err_clr is ignored; drop and underflow behaviour is otherwise identical.
// TESTING
//   - Reset with IN_RESET=60 -> dp_ioIn=60, dp_in_avail=0, host_in_ready=1, host_out_valid=0.
//   - Pushes 0x0001..0x0004 with host_out_ready=0 -> full. A push of 0x0005 is dropped and
//     err[0]=1 (EN build). Draining then yields 1,2,3,4 in order; valid drops after the 4th.
//   - Full FIFO with dp_out_we (0x00AA) and host_out_ready in the same cycle -> head popped,
//     0x00AA enqueued at tail, count stays 4. Pointer wrap is exercised over 3 full cycles.
//   - Host writes 0x1234 -> next cycle dp_ioIn=0x1234, avail=1, ready=0.
//     Host holds 0x5678 valid -> not taken.
//     dp_in_re -> avail=0, dp_ioIn stays 0x1234; next edge 0x5678 is taken.
//   - dp_in_re while EMPTY -> dp_ioIn unchanged, err[1]=1. err_clr clears it.
//     err_clr coinciding with a new underflow leaves err[1]=1. Non-EN build: err stays 0.
//   - Reset pulse of 0.2 ns mid-transfer, FIFO holding 3 words -> all outputs return to
//     their reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/io_port_bridge.sv
`timescale 1ns/1ps
// io_port_bridge: host-side end of the datapath 16-bit I/O port (output FIFO plus input holding register).
// Build option: define IO_ERR_STICKY_EN to enable the sticky overflow/underflow flags on err.
module io_port_bridge #(
   parameter int          OUT_DEPTH = 4,
   parameter logic [15:0] IN_RESET  = 16'd0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] dp_ioOut,
   input  logic        dp_out_we,
   output logic [15:0] dp_ioIn,
   output logic        dp_in_avail,
   input  logic        dp_in_re,
   output logic [15:0] host_out_data,
   output logic        host_out_valid,
   input  logic        host_out_ready,
   input  logic [15:0] host_in_data,
   input  logic        host_in_valid,
   output logic        host_in_ready,
   output logic [1:0]  err,
   input  logic        err_clr
);
   // Handshakes: a transfer happens on a rising edge where valid && ready are both 1;
   // valid never depends combinationally on ready, and ready never depends on dp_in_re.

   localparam int AW = $clog2(OUT_DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic {IN_EMPTY, IN_HELD} in_state_t;

   logic [15:0]   mem [OUT_DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [CW-1:0] count;
   logic          full;
   logic          empty;
   logic          push;
   logic          pop;
   logic          drop;
   in_state_t     in_state;
   in_state_t     in_state_next;
   logic          take;
   logic          underflow;

   // ---------------- output FIFO ----------------
   assign full           = (count == CW'(OUT_DEPTH));
   assign empty          = (count == '0);
   assign host_out_valid = !empty;
   assign pop            = host_out_valid && host_out_ready;
   assign push           = dp_out_we && (!full || pop);
   assign drop           = dp_out_we && full && !pop;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= dp_ioOut;
   end

   // Storage is not reset, so the head is masked while empty to keep reset/empty output at 0.
   assign host_out_data = empty ? 16'd0 : mem[rd_ptr];

   // ---------------- input holding register ----------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) in_state <= IN_EMPTY;
      else       in_state <= in_state_next;
   end

   always_comb begin
      in_state_next = in_state;
      dp_in_avail   = 1'b0;
      host_in_ready = 1'b0;
      take          = 1'b0;
      underflow     = 1'b0;
      case (in_state)
         IN_EMPTY: begin
            host_in_ready = 1'b1;
            take          = host_in_valid;
            underflow     = dp_in_re;
            if (host_in_valid) in_state_next = IN_HELD;
         end
         IN_HELD: begin
            dp_in_avail = 1'b1;
            if (dp_in_re) in_state_next = IN_EMPTY;
         end
         default: in_state_next = IN_EMPTY;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)     dp_ioIn <= IN_RESET;
      else if (take) dp_ioIn <= host_in_data;
   end

   // ---------------- error flags ----------------
`ifdef IO_ERR_STICKY_EN
   logic [1:0] err_q;

   // A new error in the same cycle as err_clr keeps the flag set.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         err_q <= 2'b00;
      end else begin
         if (drop)         err_q[0] <= 1'b1;
         else if (err_clr) err_q[0] <= 1'b0;
         if (underflow)    err_q[1] <= 1'b1;
         else if (err_clr) err_q[1] <= 1'b0;
      end
   end

   assign err = err_q;
`else
   logic unused_err;

   assign unused_err = &{1'b0, err_clr, drop, underflow};
   assign err        = 2'b00;
`endif

endmodule

// File: tb/tb_io_port_bridge.sv
`timescale 1ns/1ps
// tb_io_port_bridge: scoreboard bench for io_port_bridge (output FIFO order, input holding register, err flags, async reset).
module tb_io_port_bridge;

  localparam int          DEPTH = 4;
  localparam logic [15:0] IN_RST = 16'd60;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [15:0] dp_ioOut = '0;
  logic        dp_out_we = 1'b0;
  logic [15:0] dp_ioIn;
  logic        dp_in_avail;
  logic        dp_in_re = 1'b0;
  logic [15:0] host_out_data;
  logic        host_out_valid;
  logic        host_out_ready = 1'b0;
  logic [15:0] host_in_data = '0;
  logic        host_in_valid = 1'b0;
  logic        host_in_ready;
  logic [1:0]  err;
  logic        err_clr = 1'b0;

  io_port_bridge #(.OUT_DEPTH(DEPTH), .IN_RESET(IN_RST)) dut (
    .clk            (clk),
    .reset          (reset),
    .dp_ioOut       (dp_ioOut),
    .dp_out_we      (dp_out_we),
    .dp_ioIn        (dp_ioIn),
    .dp_in_avail    (dp_in_avail),
    .dp_in_re       (dp_in_re),
    .host_out_data  (host_out_data),
    .host_out_valid (host_out_valid),
    .host_out_ready (host_out_ready),
    .host_in_data   (host_in_data),
    .host_in_valid  (host_in_valid),
    .host_in_ready  (host_in_ready),
    .err            (err),
    .err_clr        (err_clr)
  );

  // ---------------- scoreboard / reference model ----------------
  logic [15:0] exp_q[$];
  logic        m_avail = 1'b0;
  logic [15:0] m_in = IN_RST;
  logic [1:0]  m_err = 2'b00;
  int          checks = 0;
  int          errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_state(input string tag);
    check_eq({tag, ".out_valid"}, host_out_valid, exp_q.size() > 0);
    if (exp_q.size() > 0) check_eq({tag, ".out_head"}, host_out_data, exp_q[0]);
    check_eq({tag, ".in_avail"}, dp_in_avail, m_avail);
    check_eq({tag, ".in_ready"}, host_in_ready, !m_avail);
    check_eq({tag, ".ioIn"}, dp_ioIn, m_in);
    check_eq({tag, ".err"}, err, m_err);
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, ".out_valid"}, host_out_valid, 1'b0);
    check_eq({tag, ".out_data"}, host_out_data, 16'd0);
    check_eq({tag, ".in_avail"}, dp_in_avail, 1'b0);
    check_eq({tag, ".in_ready"}, host_in_ready, 1'b1);
    check_eq({tag, ".ioIn"}, dp_ioIn, IN_RST);
    check_eq({tag, ".err"}, err, 2'b00);
  endtask

  // ---------------- driver ----------------
  // Called at posedge+1; applies inputs, predicts the edge, checks at the next posedge+1.
  task automatic cycle(input string tag, input logic we, input logic [15:0] wd, input logic rdy,
                       input logic hv, input logic [15:0] hd, input logic re, input logic clr);
    logic pop, push, drop, under;
    dp_out_we = we; dp_ioOut = wd; host_out_ready = rdy;
    host_in_valid = hv; host_in_data = hd; dp_in_re = re; err_clr = clr;
    #1;
    pop = rdy && (exp_q.size() > 0);
    if (pop) check_eq({tag, ".pop_data"}, host_out_data, exp_q[0]);
    push  = we && ((exp_q.size() < DEPTH) || pop);
    drop  = we && !push;
    under = re && !m_avail;
    @(posedge clk);
    #1;
    if (pop)  void'(exp_q.pop_front());
    if (push) exp_q.push_back(wd);
    if (m_avail) begin
      if (re) m_avail = 1'b0;
    end else if (hv) begin
      m_avail = 1'b1;
      m_in    = hd;
    end
`ifdef IO_ERR_STICKY_EN
    if (drop)       m_err[0] = 1'b1;
    else if (clr)   m_err[0] = 1'b0;
    if (under)      m_err[1] = 1'b1;
    else if (clr)   m_err[1] = 1'b0;
`else
    if (drop || under || clr) m_err = 2'b00;
`endif
    check_state(tag);
  endtask

  task automatic idle(input string tag);
    cycle(tag, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("rst_hold");
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_state("rst_release");

    // fill to full, drop the fifth word, then drain in order
    for (int i = 1; i <= 4; i++) cycle("fill", 1'b1, 16'(i), 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    cycle("drop", 1'b1, 16'h0005, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cycle("drain", 1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    cycle("drained", 1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    cycle("clr_ovf", 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1);

    // push+pop while full keeps count; a further push then drops
    for (int i = 0; i < 4; i++) cycle("refill", 1'b1, 16'h0010 + 16'(i), 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    cycle("full_pp", 1'b1, 16'h00AA, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    cycle("full_chk", 1'b1, 16'h00BB, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    for (int i = 0; i < 3 * DEPTH; i++)
      cycle("wrap", 1'b1, 16'($urandom_range(0, 65535)), 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH + 1; i++) cycle("wrap_drain", 1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b1);
    cycle("empty_pp", 1'b1, 16'h00CC, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    cycle("empty_pp2", 1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);

    // input path
    cycle("in_take", 1'b0, 16'h0, 1'b0, 1'b1, 16'h1234, 1'b0, 1'b0);
    cycle("in_block", 1'b0, 16'h0, 1'b0, 1'b1, 16'h5678, 1'b0, 1'b0);
    cycle("in_consume", 1'b0, 16'h0, 1'b0, 1'b1, 16'h5678, 1'b1, 1'b0);
    cycle("in_take2", 1'b0, 16'h0, 1'b0, 1'b1, 16'h5678, 1'b0, 1'b0);
    cycle("in_consume2", 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0);

    // underflow, clear, clear coinciding with a new underflow
    cycle("under", 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
    cycle("under_clr", 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
    cycle("under_set_wins", 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
    cycle("under_clr2", 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1);

    // random mixed traffic
    for (int i = 0; i < 300; i++)
      cycle("rand", 1'($urandom_range(0, 1)), 16'($urandom_range(0, 65535)),
            1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
            16'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 7) == 0));

    // async reset pulse mid-cycle with 3 words buffered and the input register held
    cycle("pre_in", 1'b0, 16'h0, 1'b1, 1'b1, 16'h4321, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH + 1; i++) cycle("pre_flush", 1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle("pre_fill", 1'b1, 16'h0100 + 16'(i), 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    cycle("pre_under", 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    idle("pre_rst");
    dp_out_we = 1'b0; host_out_ready = 1'b0; host_in_valid = 1'b0; dp_in_re = 1'b0; err_clr = 1'b0;
    #2;
    reset = 1'b1;
    #0.1;
    check_reset_vals("async_rst");
    #0.1;
    reset = 1'b0;
    #0.1;
    check_reset_vals("async_rst_rel");
    exp_q.delete();
    m_avail = 1'b0;
    m_in    = IN_RST;
    m_err   = 2'b00;
    @(posedge clk);
    #1;
    check_state("post_rst");
    cycle("post_push", 1'b1, 16'h0777, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    cycle("post_pop", 1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);

    // ---------------- report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
